// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I constants: opcodes, next-PC select encodings,
//               canonical NOP and the instruction-fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Major opcodes (ir[6:0])
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  // Next-PC selection
  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
  localparam logic [1:0] PC_SEL_RSVD   = 2'b11;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch state encoding
  typedef logic [2:0] fetch_state_t;
  localparam fetch_state_t FS_IDLE  = 3'd0;
  localparam fetch_state_t FS_ADDR  = 3'd1;
  localparam fetch_state_t FS_DATA  = 3'd2;
  localparam fetch_state_t FS_VALID = 3'd3;
  localparam fetch_state_t FS_FAULT = 3'd4;

  // Next PC; the reserved select and a not-taken branch fall through to pc+4.
  function automatic logic [31:0] next_pc(
    input logic [1:0]  sel,
    input logic        taken,
    input logic [31:0] pc_plus4,
    input logic [31:0] target
  );
    logic [31:0] npc;
    npc = pc_plus4;
    case (sel)
      PC_SEL_BRANCH: npc = taken ? target : pc_plus4;
      PC_SEL_JUMP:   npc = target;
      default:       npc = pc_plus4;
    endcase
    return npc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_field_decode.sv
`default_nettype none
// ============================================================================
// Module      : ir_field_decode
// Description : Slices the fixed RV32I register/opcode fields out of an
//               instruction word. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_field_decode (
  input  logic [31:0] ir_i,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o
);

  // Field positions are identical for every format that has the field.
  always_comb begin
    opcode_o = ir_i[6:0];
    rd_o     = ir_i[11:7];
    funct3_o = ir_i[14:12];
    rs1_o    = ir_i[19:15];
    rs2_o    = ir_i[24:20];
    funct7_o = ir_i[31:25];
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Owns the PC, fetches over a req/gnt/rvalid handshake with
//               variable latency, latches the word into the IR and applies
//               next-PC selection on PCWrite.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fetch_en,
  input  logic        PCWrite,
  input  logic [1:0]  pc_sel,
  input  logic        branch_taken,
  input  logic [31:0] target_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        instr_valid,
  output logic        fetch_busy,
  output logic        fault
);
  import riscv_pkg::*;

  // Last DATA-cycle count before the wait is declared a timeout.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, ir_q, addr_q;
  logic [7:0]   tmo_q, tmo_d;
  logic         ir_load, addr_load;
  logic [31:0]  pc_inc;

  assign pc_inc = pc_q + 32'd4;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= FS_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, plus the load strobes for IR / fetch address
  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    ir_load   = 1'b0;
    addr_load = 1'b0;
    case (state_q)
      FS_IDLE, FS_VALID: begin
        if (fetch_en) begin
          if (pc_q[1:0] == 2'b00) begin
            state_d   = FS_ADDR;
            addr_load = 1'b1;
          end else begin
            state_d = FS_FAULT;
          end
        end
      end
      FS_ADDR: begin
        if (imem_gnt) begin
          if (imem_rvalid) begin
            state_d = FS_VALID;
            ir_load = 1'b1;
          end else begin
            state_d = FS_DATA;
            tmo_d   = 8'd0;
          end
        end
      end
      FS_DATA: begin
        if (imem_rvalid) begin
          state_d = FS_VALID;
          ir_load = 1'b1;
        end else if (tmo_q == TO_LAST) begin
          state_d = FS_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      FS_FAULT: state_d = FS_FAULT;
      default:  state_d = FS_IDLE;
    endcase
  end

  // Handshake/status outputs decoded from the registered state (glitch-free)
  always_comb begin
    imem_req    = (state_q == FS_ADDR);
    fetch_busy  = (state_q == FS_ADDR) || (state_q == FS_DATA);
    instr_valid = (state_q == FS_VALID);
    fault       = (state_q == FS_FAULT);
  end

  // Datapath registers; PC updates in any state, an in-flight fetch keeps addr_q
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q   <= RESET_PC;
      ir_q   <= NOP_INSTR;
      addr_q <= RESET_PC;
      tmo_q  <= 8'd0;
    end else begin
      tmo_q <= tmo_d;
      if (PCWrite)   pc_q   <= next_pc(pc_sel, branch_taken, pc_inc, target_addr);
      if (ir_load)   ir_q   <= imem_rdata;
      if (addr_load) addr_q <= pc_q;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = pc_inc;
  assign ir        = ir_q;
  assign imem_addr = addr_q;

  ir_field_decode u_decode (
    .ir_i     (ir_q),
    .opcode_o (opcode),
    .funct3_o (funct3),
    .funct7_o (funct7),
    .rd_o     (rd),
    .rs1_o    (rs1),
    .rs2_o    (rs2)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        fetch_en = 1'b0, PCWrite = 1'b0, branch_taken = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] target_addr = 32'h0;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req, instr_valid, fetch_busy, fault;
  logic [31:0] imem_addr, pc, pc_plus4, ir;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;

  int n_pass = 0;
  int n_total = 0;

  instr_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST), .fetch_en(fetch_en), .PCWrite(PCWrite), .pc_sel(pc_sel),
    .branch_taken(branch_taken), .target_addr(target_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .pc(pc), .pc_plus4(pc_plus4), .ir(ir), .opcode(opcode),
    .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .instr_valid(instr_valid), .fetch_busy(fetch_busy), .fault(fault)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) step();
    n_total++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h exp 00000000", pc); else n_pass++;
    n_total++; if (ir !== 32'h13) $display("FAIL rst_ir: got %h exp 00000013", ir); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h exp 00000000", imem_addr); else n_pass++;
    n_total++; if ({instr_valid, fault, fetch_busy} !== 3'b000) $display("FAIL rst_status: got %b exp 000", {instr_valid, fault, fetch_busy}); else n_pass++;
    n_total++; if (pc_plus4 !== 32'h4) $display("FAIL rst_pc4: got %h exp 00000004", pc_plus4); else n_pass++;
    RST = 1'b0;
  endtask

  task automatic test_zero_wait();
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    n_total++; if (imem_req !== 1'b1) $display("FAIL zw_req: got %b exp 1", imem_req); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL zw_valid_early: got %b exp 0", instr_valid); else n_pass++;
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    n_total++; if (instr_valid !== 1'b1) $display("FAIL zw_valid: got %b exp 1", instr_valid); else n_pass++;
    n_total++; if (ir !== 32'h0050_0093) $display("FAIL zw_ir: got %h exp 00500093", ir); else n_pass++;
    n_total++; if (opcode !== 7'h13) $display("FAIL zw_opcode: got %h exp 13", opcode); else n_pass++;
    n_total++; if (rd !== 5'd1) $display("FAIL zw_rd: got %0d exp 1", rd); else n_pass++;
    n_total++; if ({funct3, rs1, rs2, funct7} !== {3'd0, 5'd0, 5'd5, 7'd0}) $display("FAIL zw_fields: got f3=%0d rs1=%0d rs2=%0d f7=%0d exp 0/0/5/0", funct3, rs1, rs2, funct7); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL zw_req_drop: got %b exp 0", imem_req); else n_pass++;
  endtask

  task automatic test_wait_states();
    fetch_en = 1'b1;
    step();                                  // t+1: ADDR
    fetch_en = 1'b0;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL ws_valid_drop: got %b exp 0", instr_valid); else n_pass++;
    n_total++; if (fetch_busy !== 1'b1) $display("FAIL ws_busy_t1: got %b exp 1", fetch_busy); else n_pass++;
    imem_gnt = 1'b1;
    step();                                  // t+2: DATA
    imem_gnt = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      n_total++; if (fetch_busy !== 1'b1) $display("FAIL ws_busy_t%0d: got %b exp 1", i, fetch_busy); else n_pass++;
      n_total++; if (imem_addr !== 32'h0) $display("FAIL ws_addr_t%0d: got %h exp 00000000", i, imem_addr); else n_pass++;
      n_total++; if (ir !== 32'h0050_0093) $display("FAIL ws_ir_hold_t%0d: got %h exp 00500093", i, ir); else n_pass++;
      if (i < 4) step();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h4000_0033;
    step();                                  // t+5: VALID
    n_total++; if (instr_valid !== 1'b1) $display("FAIL ws_valid: got %b exp 1", instr_valid); else n_pass++;
    n_total++; if (ir !== 32'h4000_0033) $display("FAIL ws_ir: got %h exp 40000033", ir); else n_pass++;
    n_total++; if ({funct7, opcode} !== {7'h20, 7'h33}) $display("FAIL ws_fields: got f7=%h op=%h exp 20/33", funct7, opcode); else n_pass++;
    n_total++; if (fetch_busy !== 1'b0) $display("FAIL ws_busy_end: got %b exp 0", fetch_busy); else n_pass++;
    imem_rdata = 32'h1111_1111;              // stale rvalid in VALID
    step();
    imem_rvalid = 1'b0;
    n_total++; if (ir !== 32'h4000_0033) $display("FAIL ws_ir_once: got %h exp 40000033", ir); else n_pass++;
  endtask

  task automatic test_pc_update();
    PCWrite = 1'b1; pc_sel = 2'b00;
    repeat (4) step();
    n_total++; if (pc !== 32'h10) $display("FAIL pc_plus4x4: got %h exp 00000010", pc); else n_pass++;
    pc_sel = 2'b01; branch_taken = 1'b0; target_addr = 32'h40;
    step();
    n_total++; if (pc !== 32'h14) $display("FAIL pc_br_nt: got %h exp 00000014", pc); else n_pass++;
    branch_taken = 1'b1;
    step();
    n_total++; if (pc !== 32'h40) $display("FAIL pc_br_t: got %h exp 00000040", pc); else n_pass++;
    pc_sel = 2'b11;
    step();
    n_total++; if (pc !== 32'h44) $display("FAIL pc_rsvd: got %h exp 00000044", pc); else n_pass++;
    pc_sel = 2'b10; target_addr = 32'hFFFF_FFFC;
    step();
    n_total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL pc_jump: got %h exp fffffffc", pc); else n_pass++;
    n_total++; if (pc_plus4 !== 32'h0) $display("FAIL pc4_wrap: got %h exp 00000000", pc_plus4); else n_pass++;
    pc_sel = 2'b00;
    step();
    n_total++; if (pc !== 32'h0) $display("FAIL pc_wrap: got %h exp 00000000", pc); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL pc_wrap_fault: got %b exp 0", fault); else n_pass++;
    // PCWrite together with fetch_en: fetch uses the old PC
    pc_sel = 2'b10; target_addr = 32'h80; fetch_en = 1'b1;
    step();
    PCWrite = 1'b0; fetch_en = 1'b0; branch_taken = 1'b0;
    n_total++; if (imem_addr !== 32'h0) $display("FAIL pcw_fetch_addr: got %h exp 00000000", imem_addr); else n_pass++;
    n_total++; if (pc !== 32'h80) $display("FAIL pcw_fetch_pc: got %h exp 00000080", pc); else n_pass++;
    imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    n_total++; if (instr_valid !== 1'b1) $display("FAIL pcw_fetch_valid: got %b exp 1", instr_valid); else n_pass++;
  endtask

  task automatic test_misaligned();
    PCWrite = 1'b1; pc_sel = 2'b10; target_addr = 32'h102;
    step();
    PCWrite = 1'b0;
    n_total++; if (pc !== 32'h102) $display("FAIL mis_pc: got %h exp 00000102", pc); else n_pass++;
    fetch_en = 1'b1;
    step();
    n_total++; if (fault !== 1'b1) $display("FAIL mis_fault: got %b exp 1", fault); else n_pass++;
    imem_gnt = 1'b1; imem_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if ({imem_req, fault, fetch_busy, instr_valid} !== 4'b0100) $display("FAIL mis_absorb_%0d: got req/fault/busy/valid=%b exp 0100", i, {imem_req, fault, fetch_busy, instr_valid}); else n_pass++;
      step();
    end
    fetch_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    n_total++; if (fault !== 1'b0) $display("FAIL to_rst_clear: got %b exp 0", fault); else n_pass++;
    fetch_en = 1'b1;
    step();                                  // ADDR
    fetch_en = 1'b0; imem_gnt = 1'b1;
    step();                                  // DATA count 0
    imem_gnt = 1'b0;
    repeat (3) step();                       // DATA count 3
    n_total++; if ({fault, fetch_busy} !== 2'b01) $display("FAIL to_pre: got fault/busy=%b exp 01", {fault, fetch_busy}); else n_pass++;
    step();
    n_total++; if ({fault, fetch_busy} !== 2'b10) $display("FAIL to_fault: got fault/busy=%b exp 10", {fault, fetch_busy}); else n_pass++;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    n_total++; if (ir !== 32'h13) $display("FAIL to_late_ir: got %h exp 00000013", ir); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL to_late_valid: got %b exp 0", instr_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    PCWrite = 1'b1; pc_sel = 2'b10; target_addr = 32'h20;
    step();
    PCWrite = 1'b0; fetch_en = 1'b1;
    step();                                  // ADDR at 0x20
    fetch_en = 1'b0;
    n_total++; if ({imem_req, imem_addr} !== {1'b1, 32'h20}) $display("FAIL rm_req: got req=%b addr=%h exp 1/00000020", imem_req, imem_addr); else n_pass++;
    imem_gnt = 1'b1;
    step();                                  // DATA
    imem_gnt = 1'b0;
    #2 RST = 1'b1;
    #1;
    n_total++; if ({imem_req, fetch_busy} !== 2'b00) $display("FAIL rm_async: got req/busy=%b exp 00", {imem_req, fetch_busy}); else n_pass++;
    n_total++; if (pc !== 32'h0) $display("FAIL rm_pc: got %h exp 00000000", pc); else n_pass++;
    step();
    RST = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_BABE;
    step();
    imem_rvalid = 1'b0;
    n_total++; if (ir !== 32'h13) $display("FAIL rm_stale_ir: got %h exp 00000013", ir); else n_pass++;
    n_total++; if ({instr_valid, fetch_busy} !== 2'b00) $display("FAIL rm_stale_state: got valid/busy=%b exp 00", {instr_valid, fetch_busy}); else n_pass++;
    // Reset while the request is outstanding in ADDR
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    #2 RST = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rm_addr_req: got %b exp 0", imem_req); else n_pass++;
    step();
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_pc_update();
    test_misaligned();
    test_timeout();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
